// File: rtl/soc2_uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants,
// common to uart_tx and the future uart_rx.
package soc2_uart_pkg;

    // 50 MHz system clock, 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;   // start + 8 data + stop

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Data-register write side of the UART transmitter.
//
// Handshake: tx_data_valid is a one-cycle write strobe qualifying tx_data;
// there is no ready signal. The writer watches tx_hold_full: a write while
// the holding register is full and not draining is dropped and raises the
// sticky tx_overrun, which stays set until overrun_clr. tx_data_ack pulses
// in the last cycle of each stop bit.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ack;
    logic       tx_busy;
    logic       tx_hold_full;
    logic       tx_overrun;
    logic       overrun_clr;
    logic       txd;

    modport master (
        output tx_data, tx_data_valid, overrun_clr,
        input  tx_data_ack, tx_busy, tx_hold_full, tx_overrun, txd
    );

    modport slave (
        input  tx_data, tx_data_valid, overrun_clr,
        output tx_data_ack, tx_busy, tx_hold_full, tx_overrun, txd
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restarts on request and
// flags the last cycle of each bit period.
module uart_baud_tick
    import soc2_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick
);
    localparam int             CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit counter, wrapping at the end of every bit period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register behind the shift
// register, so a second byte can be queued while a frame is on the line.
module uart_tx
    import soc2_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  tx_data,
    input  logic        tx_data_valid,
    output logic        tx_data_ack,
    output logic        tx_busy,
    output logic        tx_hold_full,
    output logic        tx_overrun,
    input  logic        overrun_clr,
    output logic        txd,
    output uart_state_e dbg_state
);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e state, state_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift_q, shift_next;
    logic [7:0]  hold_q, hold_next;
    logic        hold_full_q, hold_full_next;
    logic        overrun_q;
    logic        overrun_set;
    logic        txd_q, txd_next;
    logic        wr_armed_q;
    logic        wr;
    logic        tick;
    logic        frame_end;
    logic        baud_restart;

    // A write coincident with reset release is ignored.
    assign wr        = tx_data_valid & wr_armed_q;
    assign frame_end = (state == ST_STOP) && tick;

    // Counter sits at 0 in IDLE and restarts on every state change.
    assign baud_restart = (state == ST_IDLE) || (state_next != state);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .resetn  (resetn),
        .restart (baud_restart),
        .tick    (tick)
    );

    // Next-state, datapath and holding-register decisions.
    always_comb begin
        state_next     = state;
        bit_idx_next   = bit_idx;
        shift_next     = shift_q;
        hold_next      = hold_q;
        hold_full_next = hold_full_q;
        overrun_set    = 1'b0;
        txd_next       = 1'b1;

        case (state)
            ST_IDLE: begin
                if (wr) begin
                    state_next = ST_START;
                    shift_next = tx_data;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == BIT_LAST) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (hold_full_q) begin
                        // Held byte goes out next; a write in this same cycle
                        // refills the holding register instead of overrunning.
                        state_next     = ST_START;
                        shift_next     = hold_q;
                        hold_full_next = wr;
                        if (wr) begin
                            hold_next = tx_data;
                        end
                    end else if (wr) begin
                        state_next = ST_START;
                        shift_next = tx_data;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Writes during a frame (other than at its last cycle) queue or drop.
        if (wr && (state != ST_IDLE) && !frame_end) begin
            if (!hold_full_q) begin
                hold_next      = tx_data;
                hold_full_next = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shift_next[0];
            default:  txd_next = 1'b1;
        endcase
    end

    // State, datapath, flags and the registered serial line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            bit_idx     <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            txd_q       <= 1'b1;
            wr_armed_q  <= 1'b0;
        end else begin
            state       <= state_next;
            bit_idx     <= bit_idx_next;
            shift_q     <= shift_next;
            hold_q      <= hold_next;
            hold_full_q <= hold_full_next;
            txd_q       <= txd_next;
            wr_armed_q  <= 1'b1;
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign txd          = txd_q;
    assign tx_busy      = (state != ST_IDLE);
    assign tx_data_ack  = frame_end;
    assign tx_hold_full = hold_full_q;
    assign tx_overrun   = overrun_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4. A frame-level model predicts every
// output per cycle; a line decoder recovers the transmitted bytes.
module tb_uart_tx;
    import soc2_uart_pkg::*;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if   u_if ();
    uart_state_e dbg_state;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .tx_data       (u_if.tx_data),
        .tx_data_valid (u_if.tx_data_valid),
        .tx_data_ack   (u_if.tx_data_ack),
        .tx_busy       (u_if.tx_busy),
        .tx_hold_full  (u_if.tx_hold_full),
        .tx_overrun    (u_if.tx_overrun),
        .overrun_clr   (u_if.overrun_clr),
        .txd           (u_if.txd),
        .dbg_state     (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // ---------------- reference model ----------------
    // Each accepted byte becomes a frame: start cycle, ack (last) cycle, and
    // the first cycle it sits in the holding register.
    int         f_start[$];
    int         f_ack[$];
    int         f_held[$];
    logic [7:0] f_data[$];
    int         last_ack = -1;
    logic       exp_ovr  = 1'b0;
    logic       ign      = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    // Accept unless an in-flight frame and a held frame both outlive cycle t.
    task automatic model_write(input int t, input logic [7:0] d, output logic accepted);
        int n;
        int s;
        n = 0;
        for (int i = 0; i < f_ack.size(); i++) if (f_ack[i] > t) n++;
        accepted = (n < 2);
        if (accepted) begin
            s = ((last_ack > t) ? last_ack : t) + 1;
            f_start.push_back(s);
            f_ack.push_back(s + FRAME - 1);
            f_held.push_back(t + 1);
            f_data.push_back(d);
            last_ack = s + FRAME - 1;
            exp_q.push_back(d);
        end
    endtask

    function automatic logic m_txd(int c);
        logic       r;
        logic [7:0] d;
        int         b;
        r = 1'b1;
        for (int i = 0; i < f_start.size(); i++) begin
            if (c >= f_start[i] && c <= f_ack[i]) begin
                b = (c - f_start[i]) / C;
                d = f_data[i];
                if (b == 0) r = 1'b0;
                else if (b <= 8) r = d[b-1];
            end
        end
        return r;
    endfunction

    function automatic logic m_ack(int c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < f_ack.size(); i++) if (f_ack[i] == c) r = 1'b1;
        return r;
    endfunction

    function automatic logic m_busy(int c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < f_start.size(); i++)
            if (c >= f_start[i] && c <= f_ack[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic m_hold(int c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < f_start.size(); i++)
            if (c >= f_held[i] && c < f_start[i]) r = 1'b1;
        return r;
    endfunction

    // Model observes the same inputs the DUT samples at each rising edge.
    always @(posedge clk) begin
        logic acc;
        logic drop;
        drop = 1'b0;
        if (resetn) begin
            if (ign) begin
                ign = 1'b0;
            end else if (u_if.tx_data_valid === 1'b1) begin
                model_write(cyc, u_if.tx_data, acc);
                drop = !acc;
            end
            if (drop) exp_ovr = 1'b1;
            else if (u_if.overrun_clr === 1'b1) exp_ovr = 1'b0;
            while (f_ack.size() > 0 && f_ack[0] < cyc) begin
                void'(f_start.pop_front());
                void'(f_ack.pop_front());
                void'(f_held.pop_front());
                void'(f_data.pop_front());
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge resetn) begin
        f_start.delete();
        f_ack.delete();
        f_held.delete();
        f_data.delete();
        exp_q.delete();
        last_ack = -1;
        exp_ovr  = 1'b0;
    end

    always @(posedge resetn) ign = 1'b1;

    // ---------------- scoreboard monitor + line decoder ----------------
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte;

    always @(negedge clk) begin
        logic e;
        e = m_txd(cyc);
        tests_run++;
        if (u_if.txd !== e) begin
            tests_failed++;
            $display("FAIL mon_txd cyc=%0d got=%b exp=%b", cyc, u_if.txd, e);
        end
        e = m_ack(cyc);
        tests_run++;
        if (u_if.tx_data_ack !== e) begin
            tests_failed++;
            $display("FAIL mon_ack cyc=%0d got=%b exp=%b", cyc, u_if.tx_data_ack, e);
        end
        e = m_busy(cyc);
        tests_run++;
        if (u_if.tx_busy !== e || ((dbg_state != ST_IDLE) !== e)) begin
            tests_failed++;
            $display("FAIL mon_busy cyc=%0d got=%b state=%0d exp=%b", cyc, u_if.tx_busy, dbg_state, e);
        end
        e = m_hold(cyc);
        tests_run++;
        if (u_if.tx_hold_full !== e) begin
            tests_failed++;
            $display("FAIL mon_hold cyc=%0d got=%b exp=%b", cyc, u_if.tx_hold_full, e);
        end
        tests_run++;
        if (u_if.tx_overrun !== exp_ovr) begin
            tests_failed++;
            $display("FAIL mon_ovr cyc=%0d got=%b exp=%b", cyc, u_if.tx_overrun, exp_ovr);
        end

        if (!resetn) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (u_if.txd === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt > C && rx_cnt < 9 * C && (rx_cnt % C) == C / 2)
                rx_byte[rx_cnt / C - 1] = u_if.txd;
            if (rx_cnt == 9 * C + C / 2) begin
                tests_run++;
                if (u_if.txd !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rx_stop cyc=%0d got=%b exp=1", cyc, u_if.txd);
                end
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) step();
    endtask

    task automatic write_at(input int k, input logic [7:0] d);
        wait_cyc(k);
        u_if.tx_data       = d;
        u_if.tx_data_valid = 1'b1;
        step();
        u_if.tx_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (u_if.tx_busy === 1'b1 && n < 2000) begin
            step();
            n++;
        end
        tests_run++;
        if (u_if.tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_timeout cyc=%0d busy=%b exp=0", cyc, u_if.tx_busy);
        end
        repeat (3) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        u_if.tx_data       = 8'h00;
        u_if.tx_data_valid = 1'b0;
        u_if.overrun_clr   = 1'b0;
        resetn             = 1'b0;
        repeat (3) step();
        tests_run++;
        if (u_if.txd !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx_data_ack !== 1'b0 ||
            u_if.tx_hold_full !== 1'b0 || u_if.tx_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values got txd=%b busy=%b ack=%b hold=%b ovr=%b exp 1 0 0 0 0",
                     u_if.txd, u_if.tx_busy, u_if.tx_data_ack, u_if.tx_hold_full, u_if.tx_overrun);
        end
        resetn = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_single_byte();
        int n;
        rx_q.delete();
        n = cyc + 2;
        write_at(n, 8'h55);
        tests_run++;
        if (u_if.txd !== 1'b0) begin tests_failed++; $display("FAIL single_start got=%b exp=0", u_if.txd); end
        wait_cyc(n + 5);
        tests_run++;
        if (u_if.txd !== 1'b1) begin tests_failed++; $display("FAIL single_bit0 got=%b exp=1", u_if.txd); end
        wait_cyc(n + 36);
        tests_run++;
        if (u_if.txd !== 1'b0) begin tests_failed++; $display("FAIL single_bit7 got=%b exp=0", u_if.txd); end
        wait_cyc(n + 40);
        tests_run++;
        if (u_if.tx_data_ack !== 1'b1 || u_if.txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_ack got ack=%b txd=%b exp 1 1", u_if.tx_data_ack, u_if.txd);
        end
        wait_cyc(n + 41);
        tests_run++;
        if (u_if.tx_busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle got=%b exp=0", u_if.tx_busy); end
        wait_idle();
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            tests_failed++;
            $display("FAIL single_rx got n=%0d b0=%h exp n=1 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        rx_q.delete();
        n = cyc + 2;
        write_at(n, 8'hA5);
        write_at(n + 10, 8'h3C);
        tests_run++;
        if (u_if.tx_hold_full !== 1'b1) begin tests_failed++; $display("FAIL b2b_hold_set got=%b exp=1", u_if.tx_hold_full); end
        wait_cyc(n + 40);
        tests_run++;
        if (u_if.tx_hold_full !== 1'b1 || u_if.tx_data_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ack1 got hold=%b ack=%b exp 1 1", u_if.tx_hold_full, u_if.tx_data_ack);
        end
        wait_cyc(n + 41);
        tests_run++;
        if (u_if.tx_hold_full !== 1'b0 || u_if.txd !== 1'b0 || u_if.tx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_start2 got hold=%b txd=%b busy=%b exp 0 0 1", u_if.tx_hold_full, u_if.txd, u_if.tx_busy);
        end
        wait_cyc(n + 80);
        tests_run++;
        if (u_if.tx_data_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack2 got=%b exp=1", u_if.tx_data_ack); end
        wait_cyc(n + 81);
        tests_run++;
        if (u_if.tx_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got=%b exp=0", u_if.tx_busy); end
        wait_idle();
        tests_run++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL b2b_rx got n=%0d exp n=2 a5 3c", rx_q.size());
        end
    endtask

    task automatic test_overrun();
        int n;
        rx_q.delete();
        n = cyc + 2;
        write_at(n, 8'h01);
        write_at(n + 1, 8'h02);
        tests_run++;
        if (u_if.tx_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_early got=%b exp=0", u_if.tx_overrun); end
        write_at(n + 2, 8'h03);
        tests_run++;
        if (u_if.tx_overrun !== 1'b1 || u_if.tx_hold_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_set got ovr=%b hold=%b exp 1 1", u_if.tx_overrun, u_if.tx_hold_full);
        end
        wait_cyc(n + 50);
        tests_run++;
        if (u_if.tx_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got=%b exp=1", u_if.tx_overrun); end
        u_if.overrun_clr = 1'b1;
        step();
        u_if.overrun_clr = 1'b0;
        tests_run++;
        if (u_if.tx_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clr got=%b exp=0", u_if.tx_overrun); end
        wait_idle();
        tests_run++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02) begin
            tests_failed++;
            $display("FAIL ovr_rx got n=%0d exp n=2 01 02", rx_q.size());
        end
    endtask

    task automatic test_frame_end();
        int n;
        rx_q.delete();
        n = cyc + 2;
        write_at(n, 8'h11);
        write_at(n + 5, 8'h22);
        write_at(n + 40, 8'h33);
        tests_run++;
        if (u_if.tx_overrun !== 1'b0 || u_if.tx_hold_full !== 1'b1 || u_if.txd !== 1'b0) begin
            tests_failed++;
            $display("FAIL fe_refill got ovr=%b hold=%b txd=%b exp 0 1 0", u_if.tx_overrun, u_if.tx_hold_full, u_if.txd);
        end
        wait_cyc(n + 81);
        tests_run++;
        if (u_if.txd !== 1'b0 || u_if.tx_hold_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL fe_start3 got txd=%b hold=%b exp 0 0", u_if.txd, u_if.tx_hold_full);
        end
        wait_cyc(n + 121);
        tests_run++;
        if (u_if.tx_busy !== 1'b0) begin tests_failed++; $display("FAIL fe_idle got=%b exp=0", u_if.tx_busy); end
        wait_idle();
        tests_run++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33) begin
            tests_failed++;
            $display("FAIL fe_rx got n=%0d exp n=3 11 22 33", rx_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        n = cyc + 2;
        write_at(n, 8'h5A);
        write_at(n + 1, 8'hC3);
        write_at(n + 2, 8'hFF);
        wait_cyc(n + 20);
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (u_if.txd !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx_data_ack !== 1'b0 ||
            u_if.tx_hold_full !== 1'b0 || u_if.tx_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid got txd=%b busy=%b ack=%b hold=%b ovr=%b exp 1 0 0 0 0",
                     u_if.txd, u_if.tx_busy, u_if.tx_data_ack, u_if.tx_hold_full, u_if.tx_overrun);
        end
        step();
        step();
        rx_q.delete();
        // Release with a write strobe already present: that write is ignored.
        resetn             = 1'b1;
        u_if.tx_data       = 8'h99;
        u_if.tx_data_valid = 1'b1;
        step();
        u_if.tx_data_valid = 1'b0;
        tests_run++;
        if (u_if.tx_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_ignore got busy=%b exp=0", u_if.tx_busy); end
        n = cyc + 2;
        write_at(n, 8'h7E);
        tests_run++;
        if (u_if.txd !== 1'b0) begin tests_failed++; $display("FAIL rst_start got=%b exp=0", u_if.txd); end
        wait_cyc(n + 5);
        tests_run++;
        if (u_if.txd !== 1'b0) begin tests_failed++; $display("FAIL rst_bit0 got=%b exp=0", u_if.txd); end
        wait_cyc(n + 9);
        tests_run++;
        if (u_if.txd !== 1'b1) begin tests_failed++; $display("FAIL rst_bit1 got=%b exp=1", u_if.txd); end
        wait_cyc(n + 40);
        tests_run++;
        if (u_if.tx_data_ack !== 1'b1) begin tests_failed++; $display("FAIL rst_ack got=%b exp=1", u_if.tx_data_ack); end
        wait_cyc(n + 41);
        tests_run++;
        if (u_if.tx_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_idle got=%b exp=0", u_if.tx_busy); end
        wait_idle();
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h7E) begin
            tests_failed++;
            $display("FAIL rst_rx got n=%0d b0=%h exp n=1 7e", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 800; i++) begin
            u_if.tx_data       = 8'($urandom_range(0, 255));
            u_if.tx_data_valid = ($urandom_range(0, 9) == 0);
            u_if.overrun_clr   = ($urandom_range(0, 31) == 0);
            step();
        end
        u_if.tx_data_valid = 1'b0;
        u_if.overrun_clr   = 1'b0;
        wait_idle();
        tests_run++;
        if (rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < rx_q.size(); i++) begin
                tests_run++;
                if (rx_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_frame_end();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, byte to transmit.
REQ-005 SHALL have port tx_data_valid, input, 1, one-cycle write strobe for tx_data.
REQ-006 SHALL have port tx_data_ack, output, 1, one-cycle pulse in the last cycle of each stop bit.
REQ-007 SHALL have port tx_busy, output, 1, high while the FSM is not IDLE.
REQ-008 SHALL have port tx_hold_full, output, 1, high while the holding register is occupied.
REQ-009 SHALL have port tx_overrun, output, 1, sticky flag for a dropped write.
REQ-010 SHALL have port overrun_clr, input, 1, clears tx_overrun.
REQ-011 SHALL have port txd, output, 1, serial line, registered, idle high.

Function
REQ-012 SHALL send 8N1 frames: start bit 0, data bits LSB first, one stop bit 1, each bit exactly CLKS_PER_BIT cycles, so 10*CLKS_PER_BIT cycles per frame.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on load; START->DATA and DATA(bit 7)->STOP after CLKS_PER_BIT cycles; DATA advances the bit index 0..7; STOP->START if a next byte is available at frame end, else STOP->IDLE.
REQ-014 SHALL, on a write in IDLE, load the shift register directly, and drive txd low from the next cycle (latency 1).
REQ-015 SHALL, on a write while not IDLE with the holding register empty, store the byte in the holding register.
REQ-016 SHALL, at the frame-end cycle, take the next byte from the holding register if full, else from tx_data if tx_data_valid is high; the new start bit follows with no idle gap.
REQ-017 SHALL, when the holding register drains and a write arrives in the same frame-end cycle, accept the write into the holding register; no overrun.
REQ-018 SHALL, on a write while the holding register is full and not draining, drop the byte and set tx_overrun; holding register and current frame are unaffected.
REQ-019 SHALL give set priority over overrun_clr when both occur in the same cycle.
REQ-020 SHALL use a baud counter of width clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1, restarts on every state entry, and holds at 0 in IDLE.

Reset
REQ-021 SHALL, on resetn low, asynchronously force: state IDLE, txd 1, tx_data_ack 0, tx_busy 0, tx_hold_full 0, tx_overrun 0, baud counter 0, bit index 0.
REQ-022 SHALL abort a frame in progress on reset; txd returns high immediately and the held byte is discarded.
REQ-023 SHALL ignore tx_data_valid in the first cycle after reset deassertion only if it is coincident with deassertion; writes from the next cycle onward are accepted normally.

Structure
REQ-024 SHALL place the FSM state encoding and the default CLKS_PER_BIT constant in the shared package soc2_uart_pkg, for reuse by the future uart_rx.
REQ-025 SHALL allow one sub-module, uart_baud_tick (counter with restart input, end-of-bit tick output); all other logic stays flat.
REQ-026 SHALL connect to the peripherals block unchanged: tx_data/tx_data_valid from the data-register write, txd to the pad.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL verify single byte: 0x55 written at cycle N -> txd 0 in N+1..N+4; bits 1,0,1,0,1,0,1,0 each for 4 cycles in N+5..N+36; 1 in N+37..N+40; tx_data_ack only in N+40; tx_busy low from N+41.
REQ-028 SHALL verify back-to-back: 0xA5 at N and 0x3C at N+10 -> tx_hold_full high N+11..N+40; second start bit at N+41; total 80 busy cycles; two ack pulses, at N+40 and N+80.
REQ-029 SHALL verify overrun: writes 0x01, 0x02, 0x03 at N, N+1, N+2 -> 0x03 dropped; tx_overrun set from N+3; only 0x01 then 0x02 appear on txd; overrun_clr at N+50 clears it at N+51.
REQ-030 SHALL verify frame-end coincidence: 0x11 at N, 0x22 at N+5, 0x33 at N+40 -> no overrun; frames sent in order 0x11, 0x22, 0x33 with no gaps.
REQ-031 SHALL verify reset mid-frame: resetn low at N+20 -> txd 1 and all flags 0 immediately; after release, 0x7E transmits correctly with timing as in REQ-027.
